fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 37 +++
 rtl/fetch_unit_skid_buffer.sv | 35 +++
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: global widths, the
// pipe-register flush masks, the fetch state encoding and the skid entry.
// Optional feature macro: BRANCH_PREDICT_EN (LUT prediction steers next PC).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 5'b00001
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 5'b00010
`endif

package fetch_unit_pkg;

  // All-zero word decodes as a NOP downstream.
  localparam logic [`INST_WIDTH-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_FETCH    = 2'd0,  // request pending on pc
    ST_BUFFERED = 2'd1,  // response parked in the skid entry while stalled
    ST_DRAIN    = 2'd2   // redirected while a request is outstanding
  } fetch_state_t;

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    logic [`INST_WIDTH-1:0] instr;
    logic                   taken;
  } skid_entry_t;

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// Single-entry skid buffer holding a fetched word that arrived while
// decode was stalled. Clear beats load beats unload.
module fetch_skid_buffer
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  skid_entry_t i_entry,
  output logic        o_valid,
  output skid_entry_t o_entry
);

  logic        r_valid;
  skid_entry_t r_entry;

  // Capture on load, release on unload, flush on clear/reset.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake, IF/ID register, skid entry
// for stalls and a drain state for redirects that race a slow memory.
// Optional feature macro: BRANCH_PREDICT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [`NUM_PIPE_MASKS-1:0] flush,
  input  logic [`ADDR_WIDTH-1:0]     jump_address,
  output logic [`ADDR_WIDTH-1:0]     pc,
  input  logic                       take_branch,
  input  logic [`ADDR_WIDTH-1:0]     branch_predict,
  output logic                       imem_req,
  output logic [`ADDR_WIDTH-1:0]     imem_addr,
  input  logic                       imem_ready,
  input  logic [`INST_WIDTH-1:0]     imem_data,
  output logic                       if_id_valid,
  output logic [`ADDR_WIDTH-1:0]     if_id_pc,
  output logic [`INST_WIDTH-1:0]     if_id_instr,
  output logic                       if_id_branch_taken
);

  localparam logic [`NUM_PIPE_MASKS-1:0] MASK_USED = `PIPE_REG_PC | `PIPE_REG_IF_ID;

  fetch_state_t           r_state, w_next_state;
  logic [`ADDR_WIDTH-1:0] r_pc, r_pending_target, w_next_seq, w_target;
  logic                   r_if_id_valid, r_if_id_taken;
  logic [`ADDR_WIDTH-1:0] r_if_id_pc;
  logic [`INST_WIDTH-1:0] r_if_id_instr;
  logic                   w_redirect, w_kill, w_accept, w_pred, w_unused;
  logic                   w_skid_load, w_skid_unload, w_skid_valid;
  skid_entry_t            w_skid_in, w_skid_out;

  assign w_redirect = |(flush & `PIPE_REG_PC);
  assign w_kill     = |(flush & `PIPE_REG_IF_ID);

`ifdef BRANCH_PREDICT_EN
  assign w_pred   = take_branch;
  assign w_target = branch_predict;
  assign w_unused = ^(flush & ~MASK_USED);
`else
  // Without prediction every taken branch is resolved by an EX flush.
  assign w_pred   = 1'b0;
  assign w_target = '0;
  assign w_unused = ^{flush & ~MASK_USED, take_branch, branch_predict};
`endif

  // Request drops combinationally during reset so the very first
  // post-reset cycle already fetches address 0.
  assign imem_req   = ~reset && (r_state != ST_BUFFERED);
  assign imem_addr  = r_pc;  // pc is frozen during DRAIN, so the old address holds
  assign pc         = r_pc;
  assign w_accept   = (r_state == ST_FETCH) && imem_req && imem_ready && !w_redirect;
  assign w_next_seq = w_pred ? w_target : r_pc + `ADDR_WIDTH'(1);

  assign w_skid_in     = '{pc: r_pc, instr: imem_data, taken: w_pred};
  assign w_skid_load   = w_accept && stall;
  assign w_skid_unload = (r_state == ST_BUFFERED) && !stall && !w_redirect;

  fetch_skid_buffer u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_redirect),
    .i_entry  (w_skid_in),
    .o_valid  (w_skid_valid),
    .o_entry  (w_skid_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic: redirect > stall > normal.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_redirect) begin
          if (imem_req && !imem_ready) w_next_state = ST_DRAIN;
        end else if (w_accept && stall) begin
          w_next_state = ST_BUFFERED;
        end
      end
      ST_BUFFERED: if (w_redirect || !stall) w_next_state = ST_FETCH;
      ST_DRAIN:    if (imem_ready) w_next_state = ST_FETCH;
      default:     w_next_state = ST_FETCH;
    endcase
  end

  // Program counter and the redirect target parked during a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc             <= '0;
      r_pending_target <= '0;
    end else begin
      if (w_redirect) r_pending_target <= jump_address;
      case (r_state)
        ST_FETCH: begin
          if (w_redirect) begin
            if (imem_ready || !imem_req) r_pc <= jump_address;
          end else if (w_accept) begin
            r_pc <= w_next_seq;
          end
        end
        ST_BUFFERED: if (w_redirect) r_pc <= jump_address;
        ST_DRAIN: begin
          // A redirect landing with the final response is the latest one.
          if (imem_ready) r_pc <= w_redirect ? jump_address : r_pending_target;
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  // IF/ID register: kill > stall hold > load from memory or skid > bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_taken <= 1'b0;
    end else if (w_kill) begin
      r_if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (w_accept) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= imem_data;
        r_if_id_taken <= w_pred;
      end else if (w_skid_unload && w_skid_valid) begin
        r_if_id_valid <= 1'b1;
        r_if_id_pc    <= w_skid_out.pc;
        r_if_id_instr <= w_skid_out.instr;
        r_if_id_taken <= w_skid_out.taken;
      end else begin
        r_if_id_valid <= 1'b0;
      end
    end
  end

  assign if_id_valid        = r_if_id_valid;
  assign if_id_pc           = r_if_id_pc;
  assign if_id_instr        = r_if_id_instr;
  assign if_id_branch_taken = r_if_id_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. Memory returns instr = addr*4.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 5'b00001
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 5'b00010
`endif

module tb_fetch_unit;

`ifdef BRANCH_PREDICT_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  localparam logic [`NUM_PIPE_MASKS-1:0] F_NONE = '0;
  localparam logic [`NUM_PIPE_MASKS-1:0] F_PC   = `PIPE_REG_PC;
  localparam logic [`NUM_PIPE_MASKS-1:0] F_KILL = `PIPE_REG_PC | `PIPE_REG_IF_ID;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       stall = 1'b0;
  logic [`NUM_PIPE_MASKS-1:0] flush = '0;
  logic [`ADDR_WIDTH-1:0]     jump_address = '0;
  logic [`ADDR_WIDTH-1:0]     pc;
  logic                       take_branch = 1'b0;
  logic [`ADDR_WIDTH-1:0]     branch_predict = '0;
  logic                       imem_req;
  logic [`ADDR_WIDTH-1:0]     imem_addr;
  logic                       imem_ready = 1'b1;
  logic [`INST_WIDTH-1:0]     imem_data;
  logic                       if_id_valid;
  logic [`ADDR_WIDTH-1:0]     if_id_pc;
  logic [`INST_WIDTH-1:0]     if_id_instr;
  logic                       if_id_branch_taken;

  int checks = 0;
  int failures = 0;

  assign imem_data = `INST_WIDTH'(imem_addr) << 2;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .jump_address(jump_address), .pc(pc), .take_branch(take_branch),
    .branch_predict(branch_predict), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .if_id_valid(if_id_valid),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_branch_taken(if_id_branch_taken)
  );

  typedef struct {
    logic                       stall;
    logic [`NUM_PIPE_MASKS-1:0] flush;
    logic [31:0]                jump;
    logic                       take;
    logic [31:0]                pred;
    logic                       ready;
    logic                       exp_valid;
    logic [31:0]                exp_pc;
    logic                       exp_taken;
    logic [31:0]                exp_addr;
    logic                       exp_req;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic st, logic [`NUM_PIPE_MASKS-1:0] fl, logic [31:0] jmp,
                              logic tk, logic [31:0] prd, logic rdy, logic ev,
                              logic [31:0] epc, logic etk, logic [31:0] ead, logic erq);
    vec_t v;
    v.stall = st; v.flush = fl; v.jump = jmp; v.take = tk; v.pred = prd; v.ready = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_taken = etk; v.exp_addr = ead; v.exp_req = erq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] epc, input logic etk);
    check({tag, ".valid"}, {31'd0, if_id_valid}, 32'd1);
    check({tag, ".pc"}, if_id_pc, epc);
    check({tag, ".instr"}, if_id_instr, epc << 2);
    check({tag, ".taken"}, {31'd0, if_id_branch_taken}, {31'd0, etk});
  endtask

  initial begin
    // Zero-wait stream, prediction, redirect, stall/skid, drain, stall+flush, wrap.
    tbl[0]  = mk(0, F_NONE, 0,    0, 0,     1, 1, 0, 0, 1, 1);
    tbl[1]  = mk(0, F_NONE, 0,    0, 0,     1, 1, 1, 0, 2, 1);
    tbl[2]  = mk(0, F_NONE, 0,    0, 0,     1, 1, 2, 0, 3, 1);
    tbl[3]  = mk(0, F_NONE, 0,    0, 0,     1, 1, 3, 0, 4, 1);
    tbl[4]  = mk(0, F_NONE, 0,    0, 0,     1, 1, 4, 0, 5, 1);
    tbl[5]  = mk(0, F_NONE, 0,    1, 32'h20, 1, 1, 5, PE, PE ? 32'h20 : 32'd6, 1);
    tbl[6]  = mk(0, F_NONE, 0,    0, 0,     1, 1, PE ? 32'h20 : 32'd6, 0, PE ? 32'h21 : 32'd7, 1);
    tbl[7]  = mk(0, F_KILL, 8,    0, 0,     1, 0, 0, 0, 8, 1);
    tbl[8]  = mk(0, F_NONE, 0,    0, 0,     1, 1, 8, 0, 9, 1);
    tbl[9]  = mk(1, F_NONE, 0,    0, 0,     1, 1, 8, 0, 10, 0);
    tbl[10] = mk(1, F_NONE, 0,    0, 0,     1, 1, 8, 0, 10, 0);
    tbl[11] = mk(1, F_NONE, 0,    0, 0,     1, 1, 8, 0, 10, 0);
    tbl[12] = mk(0, F_NONE, 0,    0, 0,     1, 1, 9, 0, 10, 1);
    tbl[13] = mk(0, F_NONE, 0,    0, 0,     1, 1, 10, 0, 11, 1);
    tbl[14] = mk(0, F_NONE, 0,    0, 0,     1, 1, 11, 0, 12, 1);
    tbl[15] = mk(0, F_NONE, 0,    0, 0,     0, 0, 0, 0, 12, 1);
    tbl[16] = mk(0, F_KILL, 32'h40, 0, 0,   0, 0, 0, 0, 12, 1);
    tbl[17] = mk(0, F_NONE, 0,    0, 0,     0, 0, 0, 0, 12, 1);
    tbl[18] = mk(0, F_PC,   32'h50, 0, 0,   0, 0, 0, 0, 12, 1);
    tbl[19] = mk(0, F_NONE, 0,    0, 0,     1, 0, 0, 0, 32'h50, 1);
    tbl[20] = mk(0, F_NONE, 0,    0, 0,     1, 1, 32'h50, 0, 32'h51, 1);
    tbl[21] = mk(1, F_KILL, 32'h60, 0, 0,   1, 0, 0, 0, 32'h60, 1);
    tbl[22] = mk(0, F_NONE, 0,    0, 0,     1, 1, 32'h60, 0, 32'h61, 1);
    tbl[23] = mk(0, F_KILL, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 1);
    tbl[24] = mk(0, F_NONE, 0,    0, 0,     1, 1, 32'hFFFF_FFFF, 0, 0, 1);
    tbl[25] = mk(0, F_NONE, 0,    0, 0,     1, 1, 0, 0, 1, 1);

    // Reset state, with reset still asserted.
    step(); step();
    check("rst.valid", {31'd0, if_id_valid}, 32'd0);
    check("rst.pc", if_id_pc, 32'd0);
    check("rst.instr", if_id_instr, 32'd0);
    check("rst.taken", {31'd0, if_id_branch_taken}, 32'd0);
    check("rst.fetch_pc", pc, 32'd0);
    check("rst.req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst.req", {31'd0, imem_req}, 32'd1);
    check("post_rst.addr", imem_addr, 32'd0);

    for (int i = 0; i < 26; i++) begin
      stall = tbl[i].stall; flush = tbl[i].flush; jump_address = tbl[i].jump;
      take_branch = tbl[i].take; branch_predict = tbl[i].pred; imem_ready = tbl[i].ready;
      step();
      check($sformatf("v%0d.valid", i), {31'd0, if_id_valid}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        check($sformatf("v%0d.pc", i), if_id_pc, tbl[i].exp_pc);
        check($sformatf("v%0d.instr", i), if_id_instr, tbl[i].exp_pc << 2);
        check($sformatf("v%0d.taken", i), {31'd0, if_id_branch_taken}, {31'd0, tbl[i].exp_taken});
      end
      check($sformatf("v%0d.addr", i), imem_addr, tbl[i].exp_addr);
      check($sformatf("v%0d.req", i), {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
    end

    // Reset in the middle of a drain abandons it.
    stall = 0; take_branch = 0; branch_predict = 0;
    imem_ready = 0; flush = F_PC; jump_address = 32'h90;
    step();
    check("drain.addr_hold", imem_addr, 32'd1);
    flush = F_NONE; reset = 1'b1;
    step();
    check("mid_drain_rst.valid", {31'd0, if_id_valid}, 32'd0);
    check("mid_drain_rst.pc", pc, 32'd0);
    check("mid_drain_rst.req", {31'd0, imem_req}, 32'd0);
    reset = 1'b0; imem_ready = 1'b1;
    #1;
    check("mid_drain_rst.req_up", {31'd0, imem_req}, 32'd1);
    step();
    check_ifid("after_rst0", 32'd0, 1'b0);
    step();
    check_ifid("after_rst1", 32'd1, 1'b0);

    // Redirect (no IF/ID kill) while BUFFERED and stalled: IF/ID holds,
    // the parked word is dropped, fetch resumes at the target.
    stall = 1;
    step();
    check("buf.req", {31'd0, imem_req}, 32'd0);
    check_ifid("buf.hold", 32'd1, 1'b0);
    flush = F_PC; jump_address = 32'h70;
    step();
    check_ifid("buf_redir.hold", 32'd1, 1'b0);
    check("buf_redir.addr", imem_addr, 32'h70);
    check("buf_redir.req", {31'd0, imem_req}, 32'd1);
    flush = F_NONE; stall = 0;
    step();
    check_ifid("buf_redir.first", 32'h70, 1'b0);
    check("buf_redir.next_addr", imem_addr, 32'h71);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
